module_mod_counter: RTL

Parametrised modulo-N up/down counter with prescaled stepping, synchronous load, hold, and wrap or saturate end behaviour. Generalises the 2-bit free-running scan counter.
Also outputs a one-hot decode of the count and a terminal-count pulse. These drive display digit multiplexing and cascaded counter chains.
A WIDTH=2, MODULUS=4, PRESCALE=1, SATURATE=0 instance steps and wraps like the 2-bit scan counter. Its reset is asynchronous.

---
 rtl/module_mod_counter.sv | 92 +++++++++
 1 files changed

// File: rtl/module_mod_counter.sv
// Modulo-N up/down counter with prescaled stepping, clamped synchronous load,
// hold, wrap or saturate at the limits, one-hot count decode and terminal-count pulse.
module module_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stop,
    input  logic               up_dn,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count_o,
    output logic [MODULUS-1:0] sel_o,
    output logic               tc_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Comparisons are done one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   LAST_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [PW-1:0]    pre_reg, pre_next;
    logic             tc_reg, tc_next;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic             at_limit;
    logic [WIDTH-1:0] step_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            pre_reg   <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            pre_reg   <= pre_next;
            tc_reg    <= tc_next;
        end
    end

    always_comb begin
        count_ext = {1'b0, count_reg};
        load_ext  = {1'b0, load_val};
        at_limit  = up_dn ? (count_ext == LAST_EXT) : (count_ext == '0);

        // Non-limit steps can never overflow WIDTH bits, so plain +/-1 is safe.
        if (at_limit) begin
            if (SATURATE != 0) begin
                step_val = count_reg;
            end else begin
                step_val = up_dn ? '0 : LAST;
            end
        end else begin
            step_val = up_dn ? (count_reg + WIDTH'(1)) : (count_reg - WIDTH'(1));
        end

        count_next = count_reg;
        pre_next   = pre_reg;
        tc_next    = 1'b0;

        if (load) begin
            count_next = (load_ext < MOD_EXT) ? load_val : LAST;
            pre_next   = '0;
        end else if (!stop) begin
            if (pre_reg == PRE_LAST) begin
                pre_next   = '0;
                count_next = step_val;
                tc_next    = at_limit;
            end else begin
                pre_next = pre_reg + PW'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MODULUS; gi++) begin : g_sel
            assign sel_o[gi] = (count_ext == (WIDTH+1)'(gi));
        end
    endgenerate

    assign count_o = count_reg;
    assign tc_o    = tc_reg;

endmodule
